instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction-fetch stage directly downstream of the PC calculation stage.
- Takes the current PC and issues word requests to instruction memory over a valid/ready request channel, with variable-latency responses.
- Pairs each returned instruction with its PC in a small buffer and presents it to decode as the IF/ID register.
- Back-pressures the PC stage with pc_hold and discards wrong-path fetches on flush.

Parameters:
- XLEN, 32, data/address width.
- BUF_DEPTH, 2, entries in the instruction/PC buffer; power of two, >= 2.
- NOP_INSTR, 32'h00000013, value driven on if_instr when if_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- pc_in  in  XLEN  current PC from PC stage.
- pc_hold  out  1  1 = PC stage must not advance this cycle.
- flush  in  1  control redirect (taken branch/jump); kill all fetched and in-flight instructions.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  word-aligned fetch address.
- imem_resp_valid  in  1  response valid; one cycle per response; in-order; never before the accepting cycle +1.
- imem_resp_data  in  32  fetched instruction.
- id_stall  in  1  decode cannot accept this cycle.
- if_valid  out  1  IF/ID holds a valid instruction.
- if_instr  out  32  instruction, or NOP_INSTR when if_valid=0.
- if_pc  out  XLEN  PC of if_instr.
- if_pc_plus4  out  XLEN  if_pc + 4, for link register; wraps modulo 2^XLEN.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, buffer empty, count=0.
  - imem_req_valid=0, pc_hold=1, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=4.
  - Reset mid-transaction drops any outstanding request; a late response arriving after reset is ignored while state=IDLE.
- imem_req_addr = {pc_in[XLEN-1:2], 2'b00}. The low bits are ignored; no fault is raised.
- At most one request is outstanding. A pending-PC register captures the address when the request is accepted.
- FSM states: IDLE, WAIT_RESP, DRAIN.
  - IDLE: imem_req_valid = !flush && (count < BUF_DEPTH). On accept (valid && ready), go to WAIT_RESP.
  - WAIT_RESP: imem_req_valid=0.
    - On imem_resp_valid: write {resp_data, pending_pc} to the buffer tail, go to IDLE. The next request may issue in the following cycle.
    - If flush is also high that cycle: the response is discarded, go to IDLE.
    - On flush without a response: go to DRAIN.
  - DRAIN: imem_req_valid=0. On imem_resp_valid, discard the data and go to IDLE. A further flush while in DRAIN stays in DRAIN.
- Request/response throughput is therefore 1 instruction per (latency+1) cycles minimum.
- pc_hold = !(imem_req_valid && imem_req_ready) && !flush.
  - The PC advances exactly once per accepted request.
  - During flush, pc_hold=0 so the PC stage loads its redirect target.
- Buffer is a circular FIFO with head, tail and count.
  - if_valid = (count != 0). if_instr, if_pc and if_pc_plus4 come from the head entry.
  - The head pops when if_valid && !id_stall.
  - Push and pop in the same cycle leave count unchanged, so the buffer works at full.
  - Push never occurs when full, because issue is gated by count < BUF_DEPTH with one outstanding request.
  - Required invariant: count + outstanding <= BUF_DEPTH. Gate issue on (count + outstanding) < BUF_DEPTH.
- Flush takes priority over push and pop: count, head and tail are cleared, and if_valid=0 in the next cycle.
- id_stall held indefinitely: if_* outputs stay stable; the buffer fills, then the request stops and pc_hold=1.
- Pointers wrap modulo BUF_DEPTH.

Test Plan:
- Reset, then release with pc_in=0, ready=1, resp latency 1 -> req_addr=0x0 in cycle 0; resp 0x00500093 in cycle 1; if_valid=1, if_instr=0x00500093, if_pc=0, if_pc_plus4=4 in cycle 2; pc_hold=0 only in accept cycles.
- Hold imem_req_ready=0 for 3 cycles with pc_in=0x100 -> req_valid=1, req_addr=0x100 and pc_hold=1 stable for all 3 cycles; accept on the 4th cycle with pc_hold=0.
- id_stall=1 for 10 cycles, 1-cycle memory -> exactly BUF_DEPTH (2) requests issue, then req_valid=0 and pc_hold=1. On release, the instructions drain in order (PCs 0x0, 0x4) with no loss or duplication.
- flush asserted in WAIT_RESP, response for 0x8 arriving 2 cycles later -> state DRAIN; response discarded; if_valid=0; the next request uses the redirected pc_in=0x40.
- flush and imem_resp_valid in the same cycle, buffer holding 1 entry -> both discarded; if_valid=0 next cycle; if_instr=0x00000013.
- rst pulsed while WAIT_RESP, resp_valid arriving during/after reset -> outputs at reset values; the late response is not written to the buffer.
- pc_in=0xFFFFFFFC -> if_pc_plus4=0x00000000. pc_in=0x106 -> req_addr=0x104.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage with a single outstanding imem request and a small
// circular {instr, pc} buffer whose head is the IF/ID register.
`default_nettype none

module instr_fetch #(
  parameter int          XLEN      = 32,
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_hold,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            id_stall,
  output logic            if_valid,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
);

  localparam int               PTR_W   = $clog2(BUF_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    DRAIN     = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pend_pc_q, pend_pc_d;
  logic [31:0]      buf_instr_q [BUF_DEPTH];
  logic [XLEN-1:0]  buf_pc_q    [BUF_DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             outstanding, req_fire, push, pop;
  logic [1:0]       unused_pc_lsb;

  assign unused_pc_lsb = pc_in[1:0];
  assign imem_req_addr = {pc_in[XLEN-1:2], 2'b00};
  assign outstanding   = (state_q != IDLE);

  // Request visibility is suppressed while reset is held, since the FSM
  // already sits in IDLE and would otherwise advertise a request.
  assign imem_req_valid = !rst && (state_q == IDLE) && !flush &&
                          ((count_q + CNT_W'(outstanding)) < DEPTH_C);
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign pc_hold        = rst || (!req_fire && !flush);

  assign push = (state_q == WAIT_RESP) && imem_resp_valid && !flush;
  assign pop  = if_valid && !id_stall;

  assign if_valid    = (count_q != '0);
  assign if_instr    = if_valid ? buf_instr_q[head_q] : NOP_INSTR;
  assign if_pc       = buf_pc_q[head_q];
  assign if_pc_plus4 = buf_pc_q[head_q] + XLEN'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          state_d   = WAIT_RESP;
          pend_pc_d = imem_req_addr;
        end
      end
      WAIT_RESP: begin
        if (imem_resp_valid)  state_d = IDLE;
        else if (flush)       state_d = DRAIN;
      end
      // The killed response must still be consumed, even if flushed again.
      DRAIN: begin
        if (imem_resp_valid)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_instr_q[i] <= NOP_INSTR;
        buf_pc_q[i]    <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        buf_instr_q[tail_q] <= imem_resp_data;
        buf_pc_q[tail_q]    <= pend_pc_q;
      end
    end
  end

endmodule

`default_nettype wire
